// File: rtl/pio_stepper_pkg.sv
// Shared definitions for the PIO stepper controller.
// Holds the Avalon-MM register addresses, CTRL/STATUS bit positions and the
// sequencer FSM state encoding.
package pio_stepper_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_RAWOUT = 3'd1;
    localparam logic [2:0] ADDR_DIV    = 3'd2;
    localparam logic [2:0] ADDR_STEPS  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_HALF   = 2;
    localparam int CTRL_RAW    = 3;
    localparam int CTRL_IRQ_EN = 4;
    localparam int CTRL_W      = 5;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } step_state_e;

endpackage

// File: rtl/pio_stepper_ctrl_decode.sv
// stepper_phase_decode: purely combinational phase sequencer.
// Maps a phase index (0..2*NUM_PHASES-1) to the coil vector and computes the
// index that the next step lands on for the given HALF/DIR settings.
//   idx      : current phase index
//   half     : 1 = half-step (+/-1), 0 = full-step (+/-2, odd rounded down)
//   dir      : 1 = reverse (subtract)
//   coil     : coil pattern for idx
//   next_idx : index after one step, wrapped modulo 2*NUM_PHASES
module stepper_phase_decode #(
    parameter int NUM_PHASES = 4,
    parameter int IDX_W      = $clog2(2 * NUM_PHASES)
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  half,
    input  logic                  dir,
    output logic [NUM_PHASES-1:0] coil,
    output logic [IDX_W-1:0]      next_idx
);

    localparam int MOD = 2 * NUM_PHASES;

    always_comb begin : dec_p
        int k;
        int base;
        int stp;
        int nxt;
        k = int'(idx);
        // Even index: single coil k/2. Odd index: coil k/2 plus its neighbour.
        coil = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            coil[i] = (i == k / 2) || (idx[0] && (i == ((k / 2 + 1) % NUM_PHASES)));
        end
        // Full-step from an odd index first snaps down to the even position.
        base = half ? k : (k / 2) * 2;
        stp  = half ? 1 : 2;
        nxt  = dir ? (base - stp + MOD) : (base + stp);
        nxt  = nxt % MOD;
        next_idx = IDX_W'(nxt);
    end

endmodule

// File: rtl/pio_stepper_ctrl.sv
// pio_stepper_ctrl: Avalon-MM stepper motor sequencer.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   address/chipselect/
//   write_n/writedata      : zero-wait-state register writes
//   readdata               : combinational read of the addressed register
//   out_port               : registered coil drive
//   irq                    : DONE & IRQ_EN level interrupt
module pio_stepper_ctrl
    import pio_stepper_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [NUM_PHASES-1:0] out_port,
    output logic                  irq
);

    localparam int IDX_W = $clog2(2 * NUM_PHASES);

    logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
    logic [NUM_PHASES-1:0] rawout_q, rawout_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DIV_W-1:0]      presc_q,  presc_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  done_q,   done_d;
    step_state_e           state_q,  state_d;
    logic [NUM_PHASES-1:0] out_d;

    logic                  wr, steps_wr, steps_nz, en, tick, done_set;
    logic [IDX_W-1:0]      next_idx;
    logic [NUM_PHASES-1:0] coil_cur, coil_nxt;
    logic                  unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign steps_wr     = wr && (address == ADDR_STEPS);
    assign steps_nz     = (writedata[CNT_W-1:0] != '0);
    assign en           = ctrl_q[CTRL_EN];
    assign unused_wdata = ^writedata;

    // Stepping decode on the current index
    stepper_phase_decode #(.NUM_PHASES(NUM_PHASES), .IDX_W(IDX_W)) u_step (
        .idx      (idx_q),
        .half     (ctrl_q[CTRL_HALF]),
        .dir      (ctrl_q[CTRL_DIR]),
        .coil     (coil_cur),
        .next_idx (next_idx)
    );

    // Pattern of the index being loaded, so out_port tracks the registers
    // on the same edge they change.
    stepper_phase_decode #(.NUM_PHASES(NUM_PHASES), .IDX_W(IDX_W)) u_view (
        .idx      (idx_d),
        .half     (ctrl_d[CTRL_HALF]),
        .dir      (ctrl_d[CTRL_DIR]),
        .coil     (coil_nxt),
        .next_idx ()
    );

    // FSM next state
    always_comb begin
        state_d  = state_q;
        tick     = 1'b0;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (steps_wr && steps_nz) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A STEPS write takes over the cycle: reload or abort, no step.
                if (steps_wr) begin
                    if (!steps_nz) state_d = ST_IDLE;
                end else if (en && (presc_q >= div_q)) begin
                    tick = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file and datapath next values
    always_comb begin
        ctrl_d   = ctrl_q;
        rawout_d = rawout_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        done_d   = done_q;

        if (wr) begin
            case (address)
                ADDR_CTRL:   ctrl_d   = writedata[CTRL_W-1:0];
                ADDR_RAWOUT: rawout_d = writedata[NUM_PHASES-1:0];
                ADDR_DIV:    div_d    = writedata[DIV_W-1:0];
                default: ;
            endcase
        end

        if (steps_wr) begin
            cnt_d   = writedata[CNT_W-1:0];
            presc_d = '0;
        end else if (tick) begin
            cnt_d   = cnt_q - CNT_W'(1);
            presc_d = '0;
            idx_d   = next_idx;
        end else if ((state_q == ST_RUN) && en) begin
            presc_d = presc_q + DIV_W'(1);
        end

        // Set is evaluated last so it wins over a same-cycle clear.
        if (wr && (address == ADDR_STATUS) && writedata[STAT_DONE]) done_d = 1'b0;
        if (done_set) done_d = 1'b1;

        if (ctrl_d[CTRL_RAW])     out_d = rawout_d;
        else if (ctrl_d[CTRL_EN]) out_d = coil_nxt;
        else                      out_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            rawout_q <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            out_port <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            rawout_q <= rawout_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            out_port <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = 32'(ctrl_q);
            ADDR_RAWOUT: readdata = 32'(rawout_q);
            ADDR_DIV:    readdata = 32'(div_q);
            ADDR_STEPS:  readdata = 32'(cnt_q);
            ADDR_STATUS: begin
                readdata[STAT_BUSY] = (state_q == ST_RUN);
                readdata[STAT_DONE] = done_q;
            end
            default: ;
        endcase
    end

    assign irq = done_q & ctrl_q[CTRL_IRQ_EN];

    // coil_cur is the same pattern as out_port's source one edge earlier;
    // it is kept for the stepping instance's full port list.
    logic unused_coil;
    assign unused_coil = ^coil_cur;

endmodule

// File: tb/tb_pio_stepper_ctrl.sv
`timescale 1ns/1ps
module tb_pio_stepper_ctrl;

    localparam int NP  = 4;
    localparam int MOD = 2 * NP;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [NP-1:0] out_port;
    logic          irq;

    always #5 clk = ~clk;

    pio_stepper_ctrl #(.NUM_PHASES(NP), .DIV_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    typedef struct {
        logic [31:0]   rd;
        logic [NP-1:0] op;
        logic          irq;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: motor position, steps left, clocks waited
    int m_ctrl, m_raw, m_div, m_rem, m_phase, m_wait, m_done, m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 0; m_raw = 0; m_div = 0; m_rem = 0;
        m_phase = 0; m_wait = 0; m_done = 0; m_run = 0;
    endfunction

    function automatic int m_pattern(int k);
        int p;
        p = 1 << (k / 2);
        if (k % 2 == 1) p = p | (1 << ((k / 2 + 1) % NP));
        return p;
    endfunction

    function automatic int m_out();
        if (m_ctrl & 8)      return m_raw;
        else if (m_ctrl & 1) return m_pattern(m_phase);
        else                 return 0;
    endfunction

    function automatic int m_read(int a);
        case (a)
            0: return m_ctrl;
            1: return m_raw;
            2: return m_div;
            3: return m_rem;
            4: return (m_done << 1) | m_run;
            default: return 0;
        endcase
    endfunction

    function automatic void model_update(bit cs, bit wn, int a, int d);
        bit w, sw, set_done;
        int s;
        w  = cs && !wn;
        sw = w && (a == 3);
        set_done = 0;
        if (m_run != 0 && (m_ctrl & 1) && !sw) begin
            if (m_wait >= m_div) begin
                s = (m_ctrl & 4) ? 1 : 2;
                if (!(m_ctrl & 4)) m_phase = (m_phase / 2) * 2;
                m_phase = (m_ctrl & 2) ? (m_phase - s + MOD) % MOD : (m_phase + s) % MOD;
                m_rem--;
                m_wait = 0;
                if (m_rem == 0) begin
                    m_run = 0;
                    set_done = 1;
                end
            end else begin
                m_wait++;
            end
        end
        if (w) begin
            case (a)
                0: m_ctrl = d & 32'h1F;
                1: m_raw  = d & ((1 << NP) - 1);
                2: m_div  = d & 32'hFFFF;
                3: begin
                    m_rem  = d & 32'hFFFF;
                    m_wait = 0;
                    m_run  = (m_rem != 0);
                end
                4: if (d & 2) m_done = 0;
                default: ;
            endcase
        end
        if (set_done) m_done = 1;
    endfunction

    // One bus cycle: drive inputs, record what the DUT should present during
    // this cycle, then advance the model across the edge.
    task automatic cyc(input bit cs, input bit wn, input int a, input int d);
        exp_t e;
        chipselect = cs;
        write_n    = wn;
        address    = a[2:0];
        writedata  = d;
        e.rd  = m_read(a);
        e.op  = m_out();
        e.irq = (m_done != 0) && ((m_ctrl & 16) != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        model_update(cs, wn, a, d);
    endtask

    task automatic wr(input int a, input int d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int a);
        cyc(1'b0, 1'b1, a, 0);
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("readdata", readdata, e.rd);
                chk("out_port", 32'(out_port), 32'(e.op));
                chk("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    int fs_seq[5] = '{1, 2, 4, 8, 1};
    int hs_seq[3] = '{9, 8, 12};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out_port), 0);
        chk("reset_irq", 32'(irq), 0);
        chk("reset_rd", readdata, 0);
        reset_n = 1'b1;

        // Raw mode
        wr(0, 8);
        wr(1, 'hA);
        chk("raw_out", 32'(out_port), 'hA);
        chk("raw_readback", readdata, 'hA);

        // Full step forward, DIV=3
        wr(0, 0);
        wr(2, 3);
        wr(0, 1);
        wr(3, 4);
        chk("fs_start", 32'(out_port), 1);
        for (int i = 1; i < 5; i++) begin
            repeat (3) idle(4);
            chk("fs_hold", 32'(out_port), fs_seq[i-1]);
            idle(4);
            chk("fs_step", 32'(out_port), fs_seq[i]);
        end
        chk("fs_status", readdata, 2);
        wr(4, 2);

        // Half step reverse from index 0
        wr(2, 0);
        wr(0, 7);
        chk("hs_start", 32'(out_port), 1);
        wr(3, 3);
        for (int i = 0; i < 3; i++) begin
            idle(4);
            chk("hs_step", 32'(out_port), hs_seq[i]);
        end
        wr(4, 2);

        // Abort and reload
        wr(2, 10);
        wr(0, 1);
        wr(3, 20);
        repeat (5) idle(3);
        wr(3, 0);
        address = 3'd4;
        #1 chk("abort_status", readdata, 0);
        wr(3, 20);
        repeat (7) idle(3);
        wr(3, 5);
        address = 3'd3;
        #1 chk("reload_cnt", readdata, 5);
        repeat (10) idle(3);
        chk("reload_hold", readdata, 5);
        idle(3);
        chk("reload_step", readdata, 4);
        wr(3, 0);

        // IRQ, clear, and simultaneous set/clear
        wr(2, 0);
        wr(0, 'h11);
        wr(3, 2);
        idle(4);
        idle(4);
        chk("irq_set", 32'(irq), 1);
        wr(4, 2);
        chk("irq_clr", 32'(irq), 0);
        wr(3, 1);
        wr(4, 2);
        chk("irq_race", 32'(irq), 1);
        address = 3'd4;
        #1 chk("race_done", readdata, 2);
        wr(4, 2);

        // Reset mid-run
        wr(0, 1);
        wr(2, 100);
        wr(3, 50);
        repeat (20) idle(3);
        reset_n = 1'b0;
        #1;
        chk("rst_out", 32'(out_port), 0);
        chk("rst_irq", 32'(irq), 0);
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #0.5 chk("rst_rd", readdata, 0);
        end
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) idle(4);
        chk("rst_no_done", readdata, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            int r, ra;
            r  = $urandom_range(0, 13);
            ra = $urandom_range(0, 7);
            case (r)
                0: wr(0, $urandom_range(0, 31));
                1: wr(1, $urandom);
                2: wr(2, $urandom_range(0, 3));
                3: wr(3, $urandom_range(0, 6));
                4: wr(4, $urandom);
                5: cyc(1'b0, 1'b0, ra, $urandom);
                6: cyc(1'b1, 1'b1, ra, $urandom);
                7: wr(0, 1 | ($urandom_range(0, 15) << 1));
                default: idle(ra);
            endcase
        end

        repeat (2) @(posedge clk);
        #1 chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
